// File: rtl/mat_stream_driver.sv
// mat_stream_driver
//   Drives one test matrix (ramp or identity) out on an AXI-Stream master and
//   checks the framing of the result matrix coming back on an AXI-Stream
//   slave, keeping a modular checksum of every correctly framed result.
//
// Build option:
//   MAT_STREAM_DRIVER_ROW_GAP_EN  when defined, tvalid drops for one cycle
//                                 after each completed row except the last.
//
// Parameters:
//   DIM_LOG     log2 of the matrix dimension (DIM = 2**DIM_LOG)
//   DATA_WIDTH  stream word width
//
// Ports:
//   s00_axi_aclk     in   clock, all logic on the rising edge
//   s00_axi_aresetn  in   synchronous active-low reset
//   start            in   begin sending one matrix (ignored while sending)
//   sel              in   0 = ramp matrix, 1 = identity matrix
//   m00_axis_*       out  matrix stream (tvalid/tdata/tstrb/tlast), tready in
//   s00_axis_*       in   result stream (tvalid/tdata/tlast), tready out
//   tx_busy          out  matrix transmit in progress
//   rx_done          out  one-cycle pulse, a correctly framed result arrived
//   rx_err           out  sticky framing error, cleared by reset or by start
//   rx_sum           out  checksum of the last correctly framed result
//   tx_state         out  current TX FSM state (0 = IDLE, 1 = SEND)
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both 1. While tvalid is 1 and tready is 0 the master holds tdata/tlast
// stable; tvalid never depends on tready.

module mat_stream_driver #(
    parameter int DIM_LOG    = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    input  logic                    start,
    input  logic                    sel,
    output logic                    m00_axis_tvalid,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tlast,
    input  logic                    m00_axis_tready,
    input  logic                    s00_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                    s00_axis_tlast,
    output logic                    s00_axis_tready,
    output logic                    tx_busy,
    output logic                    rx_done,
    output logic                    rx_err,
    output logic [DATA_WIDTH-1:0]   rx_sum,
    output logic                    tx_state
);

    localparam int SIZE_LOG = 2 * DIM_LOG;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    tx_state_t             state_q, state_d;
    logic [SIZE_LOG-1:0]   idx_q, idx_d;
    logic                  sel_q, sel_d;
    logic                  start_clr;
    logic                  tx_valid;
    logic                  beat_last;
    logic                  row_end;
    logic                  diag;
`ifdef MAT_STREAM_DRIVER_ROW_GAP_EN
    logic                  gap_q, gap_d;
`endif

    // SIZE-1 and DIM-1 are all-ones in their fields, so compare against '1.
    assign beat_last = (idx_q == '1);
    assign row_end   = (idx_q[DIM_LOG-1:0] == '1);
    assign diag      = (idx_q[SIZE_LOG-1:DIM_LOG] == idx_q[DIM_LOG-1:0]);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sel_d     = sel_q;
        start_clr = 1'b0;
        tx_valid  = 1'b0;
`ifdef MAT_STREAM_DRIVER_ROW_GAP_EN
        gap_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SEND;
                    idx_d     = '0;
                    sel_d     = sel;
                    start_clr = 1'b1;
                end
            end
            SEND: begin
`ifdef MAT_STREAM_DRIVER_ROW_GAP_EN
                tx_valid = !gap_q;
`else
                tx_valid = 1'b1;
`endif
                if (tx_valid && m00_axis_tready) begin
                    idx_d = idx_q + 1'b1;
                    if (beat_last) begin
                        state_d = IDLE;
                    end
`ifdef MAT_STREAM_DRIVER_ROW_GAP_EN
                    gap_d = row_end && !beat_last;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sel_q   <= 1'b0;
`ifdef MAT_STREAM_DRIVER_ROW_GAP_EN
            gap_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
`ifdef MAT_STREAM_DRIVER_ROW_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    // Beat contents come straight from the registered index, so they stay
    // stable for as long as a beat is stalled. Outside a valid beat the bus
    // reads zero.
    always_comb begin
        m00_axis_tdata = '0;
        if (tx_valid) begin
            m00_axis_tdata = sel_q ? DATA_WIDTH'(diag) : DATA_WIDTH'(idx_q);
        end
    end

    assign m00_axis_tvalid = tx_valid;
    assign m00_axis_tlast  = tx_valid && beat_last;
    assign m00_axis_tstrb  = '1;
    assign tx_busy         = (state_q == SEND);
    assign tx_state        = state_q;

    // unused when the row-gap option is off
    logic unused_row_end;
    assign unused_row_end = row_end;

    // ------------------------------------------------------------------
    // RX path (independent of TX except for the error clear on start)
    // ------------------------------------------------------------------
    logic                  rx_ready_q;
    logic [SIZE_LOG-1:0]   rx_cnt_q;
    logic [DATA_WIDTH-1:0] rx_run_q;
    logic [DATA_WIDTH-1:0] rx_run_next;
    logic                  rx_accept;
    logic                  rx_cnt_full;

    assign rx_accept   = s00_axis_tvalid && rx_ready_q;
    assign rx_cnt_full = (rx_cnt_q == '1);
    assign rx_run_next = rx_run_q + s00_axis_tdata;

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            rx_ready_q <= 1'b0;
            rx_cnt_q   <= '0;
            rx_run_q   <= '0;
            rx_sum     <= '0;
            rx_done    <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            rx_ready_q <= 1'b1;
            rx_done    <= 1'b0;
            // A start clears the sticky error; a framing error on the same
            // edge overrides that clear below.
            if (start_clr) begin
                rx_err <= 1'b0;
            end
            if (rx_accept) begin
                if (rx_cnt_full && s00_axis_tlast) begin
                    rx_sum   <= rx_run_next;
                    rx_done  <= 1'b1;
                    rx_cnt_q <= '0;
                    rx_run_q <= '0;
                end else if (s00_axis_tlast || rx_cnt_full) begin
                    // early tlast, or missing tlast on the final beat
                    rx_err   <= 1'b1;
                    rx_cnt_q <= '0;
                    rx_run_q <= '0;
                end else begin
                    rx_cnt_q <= rx_cnt_q + 1'b1;
                    rx_run_q <= rx_run_next;
                end
            end
        end
    end

    assign s00_axis_tready = rx_ready_q;

endmodule
